btn_conditioner: RTL and testbench
==================================

// Module: btn_conditioner
// PURPOSE
//   Conditions the raw left/right/function push-buttons before the game core
//   (player movement and row-scan logic) consumes them. Per button:
//   2-FF synchroniser, counter debounce, press/release edge pulses, and a
//   typematic auto-repeat "step" pulse so a held left/right keeps moving.
//   Output pulses are one clk wide; the core samples them every cycle.
// PARAMETERS
//   N_BTN         3       number of buttons; bit0=left, bit1=right, bit2=function
//   DEBOUNCE_CYC  20000   sync'd input must differ from level this many consecutive cycles (>=1)
//   REPEAT_DELAY  500000  cycles from first step to first auto-repeat step (>=2)
//   REPEAT_RATE   100000  cycles between subsequent auto-repeat steps (>=1)
//   REPEAT_MASK   3'b011  bit=1 enables auto-repeat for that button
//   CNT_W         20      counter width; must hold max(DEBOUNCE_CYC,REPEAT_DELAY,REPEAT_RATE)
// PORTS
//   clk        in   1      system clock, all logic on posedge
//   rst_n      in   1      asynchronous active-low reset
//   btn_raw    in   N_BTN  raw button inputs, active-high, asynchronous to clk
//   btn_level  out  N_BTN  debounced level
//   btn_press  out  N_BTN  1-cycle pulse on debounced 0->1
//   btn_release out N_BTN  1-cycle pulse on debounced 1->0
//   btn_step   out  N_BTN  1-cycle pulse: on press, then auto-repeat while held
// BEHAVIOUR
//   - Reset (async assert, sync release via flops): sync FFs, btn_level, all
//     pulse outputs, counters = 0; every FSM -> IDLE. Outputs go 0 immediately.
//   - Channels are fully independent; simultaneous events on several bits are
//     all reported in the same cycle (core resolves left+right conflicts).
//   - Debounce: dcnt increments each cycle sync2 != level; clears when
//     sync2 == level. When dcnt == DEBOUNCE_CYC-1 and still mismatched:
//     level <= sync2, dcnt <= 0. Latency: level changes on edge DEBOUNCE_CYC+2,
//     counting the first edge that samples the new raw value as edge 1.
//   - Any raw pulse/bounce shorter than DEBOUNCE_CYC sync'd cycles: no change.
//   - btn_press/btn_release: registered, asserted in the same cycle the new
//     level first appears, exactly one cycle.
//   - Repeat FSM per button (rcnt shared per channel):
//     IDLE:   on press -> step=1 this cycle; if REPEAT_MASK bit: DELAY, rcnt=0
//     DELAY:  rcnt++; at rcnt==REPEAT_DELAY-1 -> step, REPEAT, rcnt=0
//     REPEAT: rcnt++; at rcnt==REPEAT_RATE-1 -> step, rcnt=0
//     Any state: level==0 (release) -> IDLE, rcnt=0, no step that cycle.
//     Step times for press at cycle T: T, T+REPEAT_DELAY, then +REPEAT_RATE.
//   - Mask bit 0: exactly one step per press, FSM stays IDLE.
//   - Button held through reset release: level starts 0, so it is reported as
//     a fresh press after the normal debounce latency.
//   - Counters saturate-free: they never exceed their compare value (no wrap).
// TESTING  (DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_RATE=3, N_BTN=3)
//   1. rst_n=0, btn_raw=3'b111 -> all outputs 0; release rst_n -> btn_level=111
//      and btn_press=111 for 1 cycle on edge 6; btn_step=111 same cycle.
//   2. btn_raw[0] high 3 sync'd cycles then low -> no level/press; high >=4
//      cycles -> single btn_press[0], btn_level[0]=1.
//   3. btn_raw[1] toggles every 2 cycles for 20 cycles then stays 1 -> exactly
//      one btn_press[1], zero btn_release[1].
//   4. Hold left, press at cycle T -> btn_step[0] at T, T+10, T+13, T+16...;
//      release -> one btn_release[0], no further step, FSM IDLE.
//   5. Hold function 50 cycles -> one btn_step[2]/btn_press[2], no repeats;
//      simultaneous left+right press -> btn_step=011 same cycle.
//   6. Assert rst_n mid-REPEAT -> outputs 0 asynchronously; after release with
//      raw still high -> new press after 6 edges, step sequence restarts at T.

Source files
------------

// File: rtl/btn_conditioner.sv
// Push-button conditioner: per-channel synchroniser, counter debounce, press/release
// pulses and a typematic auto-repeat step pulse for held buttons.
module btn_conditioner #(
    parameter int unsigned       N_BTN        = 3,
    parameter int unsigned       DEBOUNCE_CYC = 20000,
    parameter int unsigned       REPEAT_DELAY = 500000,
    parameter int unsigned       REPEAT_RATE  = 100000,
    parameter logic [N_BTN-1:0]  REPEAT_MASK  = N_BTN'(3'b011),
    parameter int unsigned       CNT_W        = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_step
);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

    localparam logic [CNT_W-1:0] DebLast   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DelayLast = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RateLast  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    logic [N_BTN-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [CNT_W-1:0] dcnt_q, dcnt_d;
        logic [CNT_W-1:0] rcnt_q, rcnt_d;
        logic             level_q, level_d;
        logic             press_q, release_q;
        logic             step_q, step_d;
        rep_state_e       state_q, state_d;

        always_comb begin
            level_d = level_q;
            dcnt_d  = '0;
            if (sync2_q[i] != level_q) begin
                if (dcnt_q == DebLast) begin
                    level_d = sync2_q[i];
                end else begin
                    dcnt_d = dcnt_q + CntOne;
                end
            end
        end

        // FSM looks at the level being registered so step lines up with press.
        always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q;
            step_d  = 1'b0;
            if (!level_d) begin
                state_d = StIdle;
                rcnt_d  = '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (!level_q) begin
                            step_d = 1'b1;
                            rcnt_d = '0;
                            if (REPEAT_MASK[i]) begin
                                state_d = StDelay;
                            end
                        end
                    end
                    StDelay: begin
                        if (rcnt_q == DelayLast) begin
                            step_d  = 1'b1;
                            rcnt_d  = '0;
                            state_d = StRepeat;
                        end else begin
                            rcnt_d = rcnt_q + CntOne;
                        end
                    end
                    StRepeat: begin
                        if (rcnt_q == RateLast) begin
                            step_d = 1'b1;
                            rcnt_d = '0;
                        end else begin
                            rcnt_d = rcnt_q + CntOne;
                        end
                    end
                    default: begin
                        state_d = StIdle;
                        rcnt_d  = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dcnt_q    <= '0;
                rcnt_q    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                step_q    <= 1'b0;
                state_q   <= StIdle;
            end else begin
                dcnt_q    <= dcnt_d;
                rcnt_q    <= rcnt_d;
                level_q   <= level_d;
                press_q   <= level_d & ~level_q;
                release_q <= ~level_d & level_q;
                step_q    <= step_d;
                state_q   <= state_d;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_step[i]    = step_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat timing.
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] btn_raw = 3'b000;
    logic [2:0] btn_level, btn_press, btn_release, btn_step;

    int n_cmp = 0;
    int n_err = 0;

    btn_conditioner #(
        .N_BTN       (3),
        .DEBOUNCE_CYC(4),
        .REPEAT_DELAY(10),
        .REPEAT_RATE (3),
        .REPEAT_MASK (3'b011),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_step   (btn_step)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] v_step, v_press, v_rel, v_lvl;
    int          c_press, c_rel, c_step;

    initial begin
        // 1: reset with all buttons held, then fresh press after 6 edges
        btn_raw = 3'b111;
        ticks(3);
        chk("rst_level", 32'(btn_level), 32'h0);
        chk("rst_press", 32'(btn_press), 32'h0);
        chk("rst_release", 32'(btn_release), 32'h0);
        chk("rst_step", 32'(btn_step), 32'h0);
        rst_n = 1'b1;
        ticks(5);
        chk("t1_level_e5", 32'(btn_level), 32'h0);
        tick();
        chk("t1_level_e6", 32'(btn_level), 32'h7);
        chk("t1_press_e6", 32'(btn_press), 32'h7);
        chk("t1_step_e6", 32'(btn_step), 32'h7);
        tick();
        chk("t1_pulse_e7", 32'({btn_press, btn_step}), 32'h0);
        btn_raw = 3'b000;
        ticks(5);
        chk("t1_rel_e5", 32'(btn_release), 32'h0);
        tick();
        chk("t1_rel_e6", 32'({btn_release, btn_level, btn_step}), 32'h1c0);
        ticks(2);

        // 2: 3-cycle glitch ignored, then a real press
        btn_raw[0] = 1'b1;
        ticks(3);
        btn_raw[0] = 1'b0;
        v_lvl = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            v_lvl[0] = v_lvl[0] | btn_level[0];
            v_lvl[1] = v_lvl[1] | btn_press[0];
        end
        chk("t2_glitch", v_lvl, 32'h0);
        btn_raw[0] = 1'b1;
        ticks(5);
        chk("t2_level_e5", 32'(btn_level), 32'h0);
        tick();
        chk("t2_press", 32'({btn_level, btn_press, btn_step}), 32'h049);

        // 4: held left auto-repeats at T+10, +13, +16, +19; release at T+22
        v_step = '0; v_rel = '0; v_lvl = '0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            v_step[k] = btn_step[0];
            v_rel[k]  = btn_release[0];
            v_lvl[k]  = btn_level[0];
            if (k == 16) btn_raw[0] = 1'b0;
        end
        chk("t4_steps", v_step, (32'h1 << 10) | (32'h1 << 13) | (32'h1 << 16) | (32'h1 << 19));
        chk("t4_release", v_rel, 32'h1 << 22);
        chk("t4_level", v_lvl, 32'h003f_fffe);

        // 3: bouncing right button gives one press, no release
        c_press = 0; c_rel = 0;
        for (int k = 0; k < 10; k++) begin
            btn_raw[1] = 1'b1;
            tick(); c_press += int'(btn_press[1]); c_rel += int'(btn_release[1]);
            tick(); c_press += int'(btn_press[1]); c_rel += int'(btn_release[1]);
            btn_raw[1] = 1'b0;
            tick(); c_press += int'(btn_press[1]); c_rel += int'(btn_release[1]);
            tick(); c_press += int'(btn_press[1]); c_rel += int'(btn_release[1]);
        end
        btn_raw[1] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick(); c_press += int'(btn_press[1]); c_rel += int'(btn_release[1]);
        end
        chk("t3_press_cnt", 32'(c_press), 32'd1);
        chk("t3_release_cnt", 32'(c_rel), 32'd0);
        chk("t3_level", 32'(btn_level), 32'h2);
        btn_raw[1] = 1'b0;
        ticks(8);

        // 5: function button never repeats; left+right press together
        btn_raw = 3'b100;
        c_press = 0; c_step = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            c_press += int'(btn_press[2]);
            c_step  += int'(btn_step[2]);
        end
        chk("t5_fn_press", 32'(c_press), 32'd1);
        chk("t5_fn_step", 32'(c_step), 32'd1);
        btn_raw = 3'b000;
        ticks(8);
        btn_raw = 3'b011;
        ticks(5);
        chk("t5_dual_e5", 32'(btn_step), 32'h0);
        tick();
        chk("t5_dual_step", 32'({btn_press, btn_step}), 32'h1b);
        btn_raw = 3'b000;
        ticks(8);

        // 6: reset mid-repeat, then the held button restarts its sequence
        btn_raw = 3'b001;
        ticks(17);
        chk("t6_pre_level", 32'(btn_level), 32'h1);
        rst_n = 1'b0;
        #2;
        chk("t6_async_rst", 32'({btn_level, btn_press, btn_release, btn_step}), 32'h0);
        ticks(2);
        rst_n = 1'b1;
        v_step = '0; v_press = '0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            v_step[k]  = btn_step[0];
            v_press[k] = btn_press[0];
        end
        chk("t6_press", v_press, 32'h1 << 6);
        chk("t6_steps", v_step, (32'h1 << 6) | (32'h1 << 16) | (32'h1 << 19));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
